// File: rtl/register_dump_reader.sv
// rtl/register_dump_reader.sv - walks an inclusive register range and streams {index, data} words
// Every fetched word is held in output registers until the consumer accepts it.

module register_dump_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] first_reg,
   input  logic [ADDR_WIDTH-1:0] last_reg,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cur, cur_nxt;
   logic [ADDR_WIDTH-1:0] lst, lst_nxt;
   logic                  valid_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic [ADDR_WIDTH-1:0] index_nxt;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state     <= IDLE;
         cur       <= '0;
         lst       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cur       <= cur_nxt;
         lst       <= lst_nxt;
         out_valid <= valid_nxt;
         out_data  <= data_nxt;
         out_index <= index_nxt;
         busy      <= (state_nxt != IDLE);
         done      <= (state_nxt == DONE);
      end
   end

   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      lst_nxt   = lst;
      valid_nxt = out_valid;
      data_nxt  = out_data;
      index_nxt = out_index;
      rd_addr   = '0;
      case (state)
         IDLE: begin
            // An empty range still reports completion so the requester is never left waiting.
            if (start) begin
               if (first_reg <= last_reg) begin
                  cur_nxt   = first_reg;
                  lst_nxt   = last_reg;
                  state_nxt = FETCH;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         FETCH: begin
            rd_addr   = cur;
            data_nxt  = rd_data;
            index_nxt = cur;
            valid_nxt = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            // Compare before incrementing so a range ending at the top index never wraps.
            if (out_valid && out_ready) begin
               valid_nxt = 1'b0;
               if (cur == lst) begin
                  state_nxt = DONE;
               end else begin
                  cur_nxt   = cur + 1'b1;
                  state_nxt = FETCH;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_register_dump_reader.sv
// tb/tb_register_dump_reader.sv - randomized scoreboard bench for register_dump_reader
// Expected words are queued from the register-file model at start; a negedge monitor pops and compares.

module tb_register_dump_reader;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 1 << AW;

   logic          clock = 1'b0;
   logic          clear = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] first_reg = '0;
   logic [AW-1:0] last_reg = '0;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_index;
   logic          busy;
   logic          done;

   logic [DW-1:0] rf [NR];
   assign rd_data = rf[rd_addr];

   always #5 clock = ~clock;

   register_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock     (clock),
      .clear     (clear),
      .start     (start),
      .first_reg (first_reg),
      .last_reg  (last_reg),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .busy      (busy),
      .done      (done)
   );

   int               n_cmp = 0;
   int               n_err = 0;
   int               ready_mode = 0;
   logic [AW+DW-1:0] exp_q [$];
   logic [AW+DW-1:0] exp_word;
   int               done_cnt = 0;
   int               done_base = 0;
   int               neg_cnt = 0;
   int               hs_neg = 0;
   int               done_neg = 0;
   logic             held_prev = 1'b0;
   logic [DW-1:0]    prev_data = '0;
   logic [AW-1:0]    prev_index = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: stability while stalled, ordered word checks, done pulse bookkeeping.
   always @(negedge clock) begin
      neg_cnt++;
      if (clear) begin
         held_prev = 1'b0;
      end else begin
         if (held_prev) begin
            check("held_valid", 64'(out_valid), 64'd1);
            check("held_word", 64'({out_index, out_data}), 64'({prev_index, prev_data}));
         end
         if (out_valid && out_ready) begin
            hs_neg = neg_cnt;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_word: got index %0d data %0h expected none", out_index, out_data);
            end else begin
               exp_word = exp_q.pop_front();
               check("word", 64'({out_index, out_data}), 64'(exp_word));
            end
         end
         if (done) begin
            done_cnt++;
            done_neg = neg_cnt;
         end
         held_prev  = out_valid && !out_ready;
         prev_data  = out_data;
         prev_index = out_index;
      end
   end

   always @(posedge clock) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
      if (f <= l)
         for (int i = int'(f); i <= int'(l); i++) exp_q.push_back({i[AW-1:0], rf[i]});
      done_base = done_cnt;
      @(posedge clock);
      #1 start = 1'b1;
      first_reg = f;
      last_reg  = l;
      @(posedge clock);
      #1 start = 1'b0;
      first_reg = AW'($urandom);
      last_reg  = AW'($urandom);
   endtask

   task automatic wait_idle(input string name, input bit check_timing);
      bit ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         if (!busy && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_complete"}, 64'(ok), 64'd1);
      check({name, "_done_count"}, 64'(done_cnt - done_base), 64'd1);
      if (check_timing) check({name, "_done_latency"}, 64'(done_neg - hs_neg), 64'd1);
      exp_q.delete();
   endtask

   initial begin
      logic [AW-1:0] f, l;
      bit            seen;
      int            base;

      for (int i = 0; i < NR; i++) rf[i] = $urandom;

      // Reset state, during and after clear.
      repeat (3) @(negedge clock);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_rd_addr", 64'(rd_addr), 64'd0);
      @(posedge clock);
      #1 clear = 1'b0;
      @(negedge clock);
      check("post_rst_valid", 64'(out_valid), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);

      // r3..r5 with consumer always ready; also checks first-word latency.
      rf[3] = 32'hA;
      rf[4] = 32'hB;
      rf[5] = 32'hC;
      ready_mode = 1;
      do_start(5'd3, 5'd5);
      @(negedge clock);
      check("t2_fetch_busy", 64'(busy), 64'd1);
      check("t2_fetch_valid", 64'(out_valid), 64'd0);
      check("t2_fetch_rd_addr", 64'(rd_addr), 64'd3);
      @(negedge clock);
      check("t2_first_valid", 64'(out_valid), 64'd1);
      wait_idle("t2", 1'b1);

      // Single word stalled 10 cycles; a register write after fetch must not leak through.
      ready_mode = 0;
      do_start(5'd7, 5'd7);
      repeat (5) @(negedge clock);
      rf[7] = ~rf[7];
      repeat (5) @(negedge clock);
      check("t3_stalled_valid", 64'(out_valid), 64'd1);
      ready_mode = 1;
      wait_idle("t3", 1'b1);

      // Reversed range: no words, one-cycle done and busy.
      ready_mode = 1;
      do_start(5'd9, 5'd2);
      @(negedge clock);
      check("t4_done", 64'(done), 64'd1);
      check("t4_busy", 64'(busy), 64'd1);
      check("t4_valid", 64'(out_valid), 64'd0);
      @(negedge clock);
      check("t4_done_drop", 64'(done), 64'd0);
      check("t4_busy_drop", 64'(busy), 64'd0);
      check("t4_done_count", 64'(done_cnt - done_base), 64'd1);

      // Full dump with random backpressure; stray start pulses must be ignored.
      for (int i = 0; i < NR; i++) rf[i] = $urandom;
      ready_mode = 2;
      do_start(5'd0, 5'd31);
      for (int k = 0; k < 3; k++) begin
         repeat (4) @(posedge clock);
         #1 start = 1'b1;
         first_reg = AW'($urandom);
         last_reg  = AW'($urandom);
         @(posedge clock);
         #1 start = 1'b0;
      end
      wait_idle("t5", 1'b1);

      // Random ranges with random backpressure.
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NR; i++) rf[i] = $urandom;
         f = AW'($urandom);
         l = AW'($urandom);
         do_start(f, l);
         wait_idle($sformatf("rand%0d", k), f <= l);
      end

      // Clear while a word at index 12 is waiting, then a normal dump afterwards.
      ready_mode = 0;
      do_start(5'd12, 5'd15);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("t6_reached_send", 64'(seen), 64'd1);
      check("t6_send_index", 64'(out_index), 64'd12);
      @(posedge clock);
      #2 clear = 1'b1;
      #1;
      check("t6_clear_valid", 64'(out_valid), 64'd0);
      check("t6_clear_busy", 64'(busy), 64'd0);
      check("t6_clear_done", 64'(done), 64'd0);
      exp_q.delete();
      base = done_cnt;
      repeat (2) @(posedge clock);
      #1 clear = 1'b0;
      repeat (4) @(negedge clock);
      check("t6_no_done", 64'(done_cnt - base), 64'd0);
      check("t6_idle_busy", 64'(busy), 64'd0);
      ready_mode = 1;
      do_start(5'd0, 5'd1);
      wait_idle("t6_restart", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
